// File: rtl/cook_timer_pkg.sv
// -----------------------------------------------------------------------------
// cook_timer_pkg
// Shared definitions for the microwave cook timer controller:
//   - FSM state encoding (also exported on the debug state port)
//   - field layout of the 4-digit BCD preset {min_tens, min_ones, sec_tens, sec_ones}
//   - BCD digit validity helper
// -----------------------------------------------------------------------------
package cook_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int BCD_MAX  = 9;
    localparam int DIGIT_W  = 4;
    localparam int PRESET_W = 4 * DIGIT_W;

    // Bit offsets of each digit inside the preset word
    localparam int SEC_ONES_LSB = 0;
    localparam int SEC_TENS_LSB = 4;
    localparam int MIN_ONES_LSB = 8;
    localparam int MIN_TENS_LSB = 12;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/cook_timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// cook_timer_ctrl_if
// Bundles the front-panel inputs and the counter-chain control signals of the
// cook timer controller.
//   master : the controller (reads buttons/keypad/timer_zero, drives the chain)
//   slave  : the environment (panel + counter chain)
// Signals:
//   startn/stopn/clearn  active-low button levels
//   door_closed          1 = door closed
//   keypad_valid/digit   one-cycle keypad strobe and BCD digit
//   timer_zero           chain reached 00:00
//   load_data/loadn      preset value and active-low load strobe to the chain
//   cnt_en/cnt_clrn      count-down enable and active-low clear to the chain
//   mag_on/done_lamp     magnetron enable and finished indicator
//   state                FSM state, debug
// -----------------------------------------------------------------------------
import cook_timer_pkg::*;

interface cook_timer_ctrl_if;
    logic                startn;
    logic                stopn;
    logic                clearn;
    logic                door_closed;
    logic                keypad_valid;
    logic [DIGIT_W-1:0]  keypad_digit;
    logic                timer_zero;
    logic [PRESET_W-1:0] load_data;
    logic                loadn;
    logic                cnt_en;
    logic                cnt_clrn;
    logic                mag_on;
    logic                done_lamp;
    logic [2:0]          state;

    modport master (
        input  startn, stopn, clearn, door_closed, keypad_valid, keypad_digit, timer_zero,
        output load_data, loadn, cnt_en, cnt_clrn, mag_on, done_lamp, state
    );

    modport slave (
        output startn, stopn, clearn, door_closed, keypad_valid, keypad_digit, timer_zero,
        input  load_data, loadn, cnt_en, cnt_clrn, mag_on, done_lamp, state
    );
endinterface

// File: rtl/cook_timer_ctrl_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-TICK_DIV counter with synchronous clear and run gate.
// Ports:
//   clk   rising-edge clock
//   clrn  asynchronous active-low reset
//   clr   synchronous clear (wins over run)
//   run   advance the count this cycle
//   tick  high in the cycle the count sits at TICK_DIV-1 while running
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic clrn,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Tick is combinational so the wrap cycle itself carries the pulse.
    assign tick = run && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/cook_timer_ctrl.sv
// -----------------------------------------------------------------------------
// cook_timer_ctrl
// Sequencing controller for the microwave countdown chain. Collects keypad
// digits into a 4-digit BCD preset, loads it into the chain, issues one
// count enable per cooking second, handles pause/resume/clear, drives the
// magnetron and the done lamp, and ends cooking on the chain's zero flag.
// Parameters:
//   TICK_DIV     clk cycles per countdown second (>= 2)
//   DONE_CYCLES  seconds the done lamp stays lit before returning to IDLE
// Ports:
//   clk   rising-edge clock
//   clrn  asynchronous active-low reset
//   io    cook_timer_ctrl_if.master (panel inputs, chain controls, debug state)
// -----------------------------------------------------------------------------
import cook_timer_pkg::*;

module cook_timer_ctrl #(
    parameter int TICK_DIV    = 100,
    parameter int DONE_CYCLES = 5
) (
    input  logic              clk,
    input  logic              clrn,
    cook_timer_ctrl_if.master io
);

    state_t              state_q;
    logic [PRESET_W-1:0] preset_q;
    logic                loadn_q;
    logic                cnt_clrn_q;
    logic                startn_q, stopn_q, clearn_q;

    logic start_ev, stop_ev, clear_ev, key_ok;
    logic cook_abort;
    logic sec_clr, sec_run, sec_tick;
    logic done_clr, done_run, done_tick;

    // Shift a new digit into sec_ones; the old min_tens digit falls off.
    function automatic logic [PRESET_W-1:0] shift_digit(input logic [PRESET_W-1:0] p,
                                                        input logic [DIGIT_W-1:0]  d);
        logic [PRESET_W-1:0] r;
        r = '0;
        r[MIN_TENS_LSB +: DIGIT_W] = p[MIN_ONES_LSB +: DIGIT_W];
        r[MIN_ONES_LSB +: DIGIT_W] = p[SEC_TENS_LSB +: DIGIT_W];
        r[SEC_TENS_LSB +: DIGIT_W] = p[SEC_ONES_LSB +: DIGIT_W];
        r[SEC_ONES_LSB +: DIGIT_W] = d;
        return r;
    endfunction

    // Falling-edge detection against the registered previous level, so a
    // held button produces exactly one event.
    assign start_ev = startn_q & ~io.startn;
    assign stop_ev  = stopn_q  & ~io.stopn;
    assign clear_ev = clearn_q & ~io.clearn;
    assign key_ok   = io.keypad_valid && is_bcd(io.keypad_digit);

    // Any event that takes COOK out of counting this cycle (clear, stop,
    // door open); these outrank both timer_zero and the tick.
    assign cook_abort = clear_ev | stop_ev | ~io.door_closed;

    always_comb begin
        sec_clr  = (state_q == ST_LOAD) ||
                   ((state_q == ST_COOK) && !cook_abort && io.timer_zero);
        // Pausing holds the prescaler, so a resume finishes the partial second.
        sec_run  = ((state_q == ST_COOK) && !cook_abort) || (state_q == ST_DONE);
        done_clr = (state_q != ST_DONE);
        done_run = (state_q == ST_DONE) && sec_tick;
    end

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_sec_prescaler (
        .clk  (clk),
        .clrn (clrn),
        .clr  (sec_clr),
        .run  (sec_run),
        .tick (sec_tick)
    );

    // Counts seconds spent in DONE; reuses the prescaler as a wrap counter.
    tick_prescaler #(.TICK_DIV(DONE_CYCLES)) u_done_prescaler (
        .clk  (clk),
        .clrn (clrn),
        .clr  (done_clr),
        .run  (done_run),
        .tick (done_tick)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            preset_q   <= '0;
            loadn_q    <= 1'b1;
            cnt_clrn_q <= 1'b1;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
            clearn_q   <= 1'b1;
        end else begin
            startn_q   <= io.startn;
            stopn_q    <= io.stopn;
            clearn_q   <= io.clearn;
            loadn_q    <= 1'b1;
            cnt_clrn_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (clear_ev) begin
                        preset_q <= '0;
                    end else if (key_ok) begin
                        preset_q <= shift_digit(preset_q, io.keypad_digit);
                        state_q  <= ST_SET;
                    end
                end

                ST_SET: begin
                    if (clear_ev) begin
                        preset_q <= '0;
                        state_q  <= ST_IDLE;
                    end else if (start_ev && io.door_closed && (preset_q != '0)) begin
                        loadn_q <= 1'b0;
                        state_q <= ST_LOAD;
                    end else if (key_ok) begin
                        preset_q <= shift_digit(preset_q, io.keypad_digit);
                    end
                end

                ST_LOAD: begin
                    state_q <= ST_COOK;
                end

                ST_COOK: begin
                    if (clear_ev) begin
                        preset_q   <= '0;
                        cnt_clrn_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (stop_ev || !io.door_closed) begin
                        state_q <= ST_PAUSE;
                    end else if (io.timer_zero) begin
                        state_q <= ST_DONE;
                    end
                end

                ST_PAUSE: begin
                    if (clear_ev || stop_ev) begin
                        preset_q   <= '0;
                        cnt_clrn_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (start_ev && io.door_closed) begin
                        state_q <= ST_COOK;
                    end
                end

                ST_DONE: begin
                    if (clear_ev || stop_ev || !io.door_closed || io.keypad_valid || done_tick) begin
                        preset_q   <= '0;
                        cnt_clrn_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign io.state     = state_q;
    assign io.load_data = preset_q;
    assign io.loadn     = loadn_q;
    // Reset passes straight through so the chain clears while clrn is low.
    assign io.cnt_clrn  = clrn & cnt_clrn_q;
    assign io.mag_on    = (state_q == ST_COOK);
    assign io.done_lamp = (state_q == ST_DONE);
    assign io.cnt_en    = (state_q == ST_COOK) && !cook_abort && !io.timer_zero && sec_tick;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cook_timer_ctrl
// Directed scenarios followed by randomized panel activity, every cycle
// compared against a behavioural model of the cook timer.
// -----------------------------------------------------------------------------
module tb_cook_timer_ctrl;

    localparam int TICK = 4;
    localparam int DONE = 5;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    cook_timer_ctrl_if ifc ();

    cook_timer_ctrl #(.TICK_DIV(TICK), .DONE_CYCLES(DONE)) dut (
        .clk  (clk),
        .clrn (clrn),
        .io   (ifc.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: mode uses the documented state numbers, the preset
    // is kept as four decimal digits, time is counted in elapsed cycles.
    int m_mode;
    int m_dig[4];
    int m_phase;      // cycles elapsed in the current cooking second
    int m_done;       // cycles spent in DONE
    bit m_clrp;       // chain clear pulse due this cycle
    bit m_ps, m_pt, m_pc;

    // Observed values of the last sampled cycle
    logic [2:0]  o_state;
    logic [15:0] o_data;
    logic        o_loadn, o_cnt_en, o_cnt_clrn, o_mag, o_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_phase = 0;
        m_done  = 0;
        m_clrp  = 0;
        m_ps = 1; m_pt = 1; m_pc = 1;
    endtask

    function automatic int preset_value();
        return m_dig[0] * 4096 + m_dig[1] * 256 + m_dig[2] * 16 + m_dig[3];
    endfunction

    task automatic model_abort();
        m_mode = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_clrp = 1;
    endtask

    task automatic model_push(input int d);
        m_dig[0] = m_dig[1];
        m_dig[1] = m_dig[2];
        m_dig[2] = m_dig[3];
        m_dig[3] = d;
    endtask

    task automatic model_update(input bit sn, input bit tn, input bit cn, input bit dc,
                                input bit kv, input int kd, input bit tz);
        bit st_e, sp_e, cl_e;
        st_e = m_ps && !sn;
        sp_e = m_pt && !tn;
        cl_e = m_pc && !cn;
        m_clrp = 0;
        case (m_mode)
            0: begin
                if (cl_e) for (int i = 0; i < 4; i++) m_dig[i] = 0;
                else if (kv && kd <= 9) begin model_push(kd); m_mode = 1; end
            end
            1: begin
                if (cl_e) begin
                    for (int i = 0; i < 4; i++) m_dig[i] = 0;
                    m_mode = 0;
                end else if (st_e && dc && preset_value() != 0) m_mode = 2;
                else if (kv && kd <= 9) model_push(kd);
            end
            2: begin m_mode = 3; m_phase = 0; end
            3: begin
                if (cl_e) model_abort();
                else if (sp_e || !dc) m_mode = 4;
                else if (tz) begin m_mode = 5; m_done = 0; end
                else m_phase = (m_phase + 1) % TICK;
            end
            4: begin
                if (cl_e || sp_e) model_abort();
                else if (st_e && dc) m_mode = 3;
            end
            5: begin
                m_done++;
                if (cl_e || sp_e || !dc || kv || m_done == TICK * DONE) model_abort();
            end
            default: m_mode = 0;
        endcase
        m_ps = sn; m_pt = tn; m_pc = cn;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare all
    // outputs against the model, then advance the model at the rising edge.
    task automatic step(input bit sn, input bit tn, input bit cn, input bit dc,
                        input bit kv, input logic [3:0] kd, input bit tz);
        logic [23:0] got, exp;
        bit en;
        ifc.startn = sn; ifc.stopn = tn; ifc.clearn = cn; ifc.door_closed = dc;
        ifc.keypad_valid = kv; ifc.keypad_digit = kd; ifc.timer_zero = tz;
        #1;
        o_state = ifc.state; o_data = ifc.load_data; o_loadn = ifc.loadn;
        o_cnt_en = ifc.cnt_en; o_cnt_clrn = ifc.cnt_clrn; o_mag = ifc.mag_on; o_done = ifc.done_lamp;
        en = (m_mode == 3) && !(m_pc && !cn) && !(m_pt && !tn) && dc && !tz && (m_phase == TICK - 1);
        got = {o_state, o_data, o_loadn, o_cnt_en, o_cnt_clrn, o_mag, o_done};
        exp = {3'(m_mode), 16'(preset_value()), m_mode != 2, en, !m_clrp, m_mode == 3, m_mode == 5};
        chk("cycle_outputs", 32'(got), 32'(exp));
        @(posedge clk);
        model_update(sn, tn, cn, dc, kv, int'(kd), tz);
        @(negedge clk);
    endtask

    task automatic idle(input bit tz);
        step(1, 1, 1, 1, 0, 4'h0, tz);
    endtask

    task automatic key(input logic [3:0] d);
        step(1, 1, 1, 1, 1, d, 0);
    endtask

    initial begin
        logic [7:0] mask;
        int lit;
        model_reset();
        ifc.startn = 1; ifc.stopn = 1; ifc.clearn = 1; ifc.door_closed = 1;
        ifc.keypad_valid = 0; ifc.keypad_digit = 0; ifc.timer_zero = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs",
            32'({ifc.state, ifc.load_data, ifc.loadn, ifc.cnt_en, ifc.cnt_clrn, ifc.mag_on, ifc.done_lamp}),
            32'({3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        clrn = 1'b1;

        // Preset entry, invalid digit dropped
        idle(0);
        key(4'h1); key(4'h3); key(4'h0); key(4'hA);
        idle(0);
        chk("preset_0130", 32'(o_data), 32'h0130);
        chk("set_state", 32'(o_state), 32'd1);

        // Start -> one LOAD cycle -> COOK
        step(0, 1, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        chk("load_state", 32'(o_state), 32'd2);
        chk("load_strobe", 32'(o_loadn), 32'd0);
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            idle(0);
            if (i == 0) begin
                chk("cook_state", 32'(o_state), 32'd3);
                chk("cook_mag", 32'(o_mag), 32'd1);
                chk("cook_loadn", 32'(o_loadn), 32'd1);
            end
            mask[i] = o_cnt_en;
        end
        chk("tick_every_4", 32'(mask), 32'h88);

        // timer_zero on a tick cycle suppresses the enable and ends cooking
        repeat (3) idle(0);
        idle(1);
        chk("zero_blocks_tick", 32'(o_cnt_en), 32'd0);
        lit = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (o_done) lit++;
        end
        chk("done_lamp_cycles", 32'(lit), 32'd20);
        idle(0);
        chk("done_exit_state", 32'(o_state), 32'd0);
        chk("done_exit_clrn", 32'(o_cnt_clrn), 32'd0);
        chk("done_exit_data", 32'(o_data), 32'd0);

        // Pause on door open, resume finishes the partial second
        key(4'h4); key(4'h5);
        step(0, 1, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        idle(0); idle(0);
        step(1, 1, 1, 0, 0, 4'h0, 0);
        chk("door_open_cnt_en", 32'(o_cnt_en), 32'd0);
        step(1, 1, 1, 0, 0, 4'h0, 0);
        chk("pause_state", 32'(o_state), 32'd4);
        chk("pause_mag", 32'(o_mag), 32'd0);
        idle(0);
        step(0, 1, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        chk("resume_state", 32'(o_state), 32'd3);
        chk("resume_first", 32'(o_cnt_en), 32'd0);
        idle(0);
        chk("resume_tick", 32'(o_cnt_en), 32'd1);

        // Clear and stop on the tick cycle
        repeat (3) idle(0);
        step(1, 0, 0, 1, 0, 4'h0, 0);
        chk("abort_tick", 32'(o_cnt_en), 32'd0);
        idle(0);
        chk("abort_state", 32'(o_state), 32'd0);
        chk("abort_clrn", 32'(o_cnt_clrn), 32'd0);
        chk("abort_data", 32'(o_data), 32'd0);
        idle(0);
        chk("abort_clrn_end", 32'(o_cnt_clrn), 32'd1);

        // Start rejected with zero preset or open door
        key(4'h0);
        step(0, 1, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        chk("zero_start_state", 32'(o_state), 32'd1);
        chk("zero_start_loadn", 32'(o_loadn), 32'd1);
        key(4'h7);
        step(0, 1, 1, 0, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        chk("door_start_state", 32'(o_state), 32'd1);
        chk("door_start_loadn", 32'(o_loadn), 32'd1);
        step(0, 1, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        chk("start_ok_state", 32'(o_state), 32'd2);

        // Asynchronous reset in the middle of COOK
        repeat (3) idle(0);
        #2 clrn = 1'b0;
        #1;
        chk("async_reset",
            32'({ifc.state, ifc.load_data, ifc.loadn, ifc.cnt_en, ifc.cnt_clrn, ifc.mag_on, ifc.done_lamp}),
            32'({3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        clrn = 1'b1;
        model_reset();

        // Randomized panel and chain activity
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(5) != 0, $urandom_range(7) != 0, $urandom_range(11) != 0,
                 $urandom_range(9) != 0, $urandom_range(3) == 0, 4'($urandom_range(15)),
                 $urandom_range(29) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
